// File: rtl/spi_regbank_4mb_pkg.sv
// Shared 4MB register-bank constants: address map, defaults, write decode.
// SPI_REGBANK_IRQ_EN adds IRQ_MASK at 0x0007 as a writable register.
package spi_regbank_4mb_pkg;

  localparam logic [15:0] ADDR_VERSION  = 16'h0000;
  localparam logic [15:0] ADDR_SCRATCH  = 16'h0001;
  localparam logic [15:0] ADDR_CTRL     = 16'h0002;
  localparam logic [15:0] ADDR_CMD      = 16'h0003;
  localparam logic [15:0] ADDR_STATUS   = 16'h0004;
  localparam logic [15:0] ADDR_EVENT    = 16'h0005;
  localparam logic [15:0] ADDR_CNT      = 16'h0006;
  localparam logic [15:0] ADDR_IRQ_MASK = 16'h0007;

  localparam logic [15:0] ADDR_IDLE = 16'hFFFF;

  localparam logic [31:0] DEF_VERSION      = 32'h0001_0000;
  localparam logic [31:0] DEF_BAD_ADDR_VAL = 32'hDEAD_BEEF;

  function automatic logic wr_ok(input logic [15:0] a);
`ifdef SPI_REGBANK_IRQ_EN
    return (a == ADDR_SCRATCH) || (a == ADDR_CTRL) ||
           (a == ADDR_CMD) || (a == ADDR_IRQ_MASK);
`else
    return (a == ADDR_SCRATCH) || (a == ADDR_CTRL) ||
           (a == ADDR_CMD);
`endif
  endfunction

endpackage

// File: rtl/spi_event_reg_4mb.sv
// Sticky event bits with snapshot-on-capture and masked clear-on-commit.
// A set arriving in the commit cycle wins over the clear.
module spi_event_reg_4mb
  import spi_regbank_4mb_pkg::*;
#(
  parameter int EVT_W = 16
) (
  input  logic             clk_100m,
  input  logic             rst_syn,
  input  logic [EVT_W-1:0] set,
  input  logic             capture,
  input  logic             discard,
  input  logic             commit,
  output logic [EVT_W-1:0] bits,
  output logic [EVT_W-1:0] snap
);

  logic [EVT_W-1:0] clr;

  assign clr = commit ? snap : '0;

  always_ff @(posedge clk_100m) begin
    if (rst_syn) begin
      bits <= '0;
      snap <= '0;
    end else begin
      bits <= (bits & ~clr) | set;
      if (capture)
        snap <= bits;
      else if (discard || commit)
        snap <= '0;
    end
  end

endmodule

// File: rtl/spi_regbank_4mb.sv
// SPI-slave register bank: prefetched reads, strobed writes, sticky events.
// Define SPI_REGBANK_IRQ_EN for IRQ_MASK at 0x0007 and the irq output.
module spi_regbank_4mb
  import spi_regbank_4mb_pkg::*;
#(
  parameter logic [31:0] VERSION      = DEF_VERSION,
  parameter logic [31:0] BAD_ADDR_VAL = DEF_BAD_ADDR_VAL,
  parameter int          EVT_W        = 16
) (
  input  logic             clk_100m,
  input  logic             rst_syn,
  input  logic [15:0]      addr,
  input  logic             addr_rdy,
  input  logic [31:0]      data_mosi,
  input  logic             data_mosi_rdy,
  input  logic             data_miso_rdy,
  output logic [31:0]      data_miso,
  output logic [31:0]      ctrl_out,
  output logic [31:0]      cmd_pulse,
  input  logic [31:0]      status_in,
  input  logic [EVT_W-1:0] evt_in,
  output logic             wr_err
`ifdef SPI_REGBANK_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic             addr_rdy_d;
  logic             prefetch;
  logic [15:0]      cur_addr;
  logic [31:0]      scratch;
  logic [15:0]      wr_cnt;
  logic [15:0]      rd_cnt;
  logic [31:0]      rd_mux;
  logic             commit;
  logic [EVT_W-1:0] evt_bits;
  logic [EVT_W-1:0] evt_snap;
`ifdef SPI_REGBANK_IRQ_EN
  logic [31:0]      irq_mask;
`endif

  assign commit = data_miso_rdy && (cur_addr == ADDR_EVENT);

  spi_event_reg_4mb #(
    .EVT_W(EVT_W)
  ) u_evt (
    .clk_100m(clk_100m),
    .rst_syn (rst_syn),
    .set     (evt_in),
    .capture (addr_rdy_d),
    .discard (addr_rdy),
    .commit  (commit),
    .bits    (evt_bits),
    .snap    (evt_snap)
  );

  // EVENT reads the snapshot so that exactly what is returned gets cleared
  always_comb begin
    rd_mux = BAD_ADDR_VAL;
    unique case (1'b1)
      cur_addr == ADDR_VERSION:  rd_mux = VERSION;
      cur_addr == ADDR_SCRATCH:  rd_mux = scratch;
      cur_addr == ADDR_CTRL:     rd_mux = ctrl_out;
      cur_addr == ADDR_CMD:      rd_mux = '0;
      cur_addr == ADDR_STATUS:   rd_mux = status_in;
      cur_addr == ADDR_EVENT:    rd_mux = 32'(evt_snap);
      cur_addr == ADDR_CNT:      rd_mux = {wr_cnt, rd_cnt};
`ifdef SPI_REGBANK_IRQ_EN
      cur_addr == ADDR_IRQ_MASK: rd_mux = irq_mask;
`endif
      default:                   rd_mux = BAD_ADDR_VAL;
    endcase
  end

  always_ff @(posedge clk_100m) begin
    if (rst_syn) begin
      addr_rdy_d <= 1'b0;
      prefetch   <= 1'b0;
      cur_addr   <= ADDR_IDLE;
      data_miso  <= '0;
      scratch    <= '0;
      ctrl_out   <= '0;
      cmd_pulse  <= '0;
      wr_err     <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
    end else begin
      addr_rdy_d <= addr_rdy;
      prefetch   <= addr_rdy_d;
      cmd_pulse  <= '0;
      wr_err     <= 1'b0;
      if (addr_rdy_d)
        cur_addr <= addr;
      if (prefetch)
        data_miso <= rd_mux;
      if (data_mosi_rdy) begin
        if (wr_ok(cur_addr))
          wr_cnt <= wr_cnt + 16'd1;
        else
          wr_err <= 1'b1;
        unique case (1'b1)
          cur_addr == ADDR_SCRATCH: scratch   <= data_mosi;
          cur_addr == ADDR_CTRL:    ctrl_out  <= data_mosi;
          cur_addr == ADDR_CMD:     cmd_pulse <= data_mosi;
          default: ;
        endcase
      end
      if (data_miso_rdy)
        rd_cnt <= rd_cnt + 16'd1;
    end
  end

`ifdef SPI_REGBANK_IRQ_EN
  always_ff @(posedge clk_100m) begin
    if (rst_syn) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (data_mosi_rdy && (cur_addr == ADDR_IRQ_MASK))
        irq_mask <= data_mosi;
      irq <= |(evt_bits & irq_mask[EVT_W-1:0]);
    end
  end
`endif

endmodule

// File: doc/spi_regbank_4mb.md
Name: spi_regbank_4mb

Overview:
Register bank directly downstream of the SPI slave. It consumes the slave's address, write data and strobes, and returns read data on data_miso. It holds scratch, control, command-pulse, status, sticky-event and counter registers for the rest of the 4MB logic. It runs on the same clk_100m domain as the SPI slave.

Parameters:
VERSION, 32'h0001_0000, value returned at VERSION address
BAD_ADDR_VAL, 32'hDEAD_BEEF, read value for unmapped addresses
EVT_W, 16, number of sticky event bits (1..32)

Ports:
clk_100m  in  1  system clock
rst_syn  in  1  synchronous reset, active-high
addr  in  16  register address from SPI slave, valid from 1 cycle after addr_rdy
addr_rdy  in  1  one-cycle pulse, address phase complete
data_mosi  in  32  write data, valid in the data_mosi_rdy cycle
data_mosi_rdy  in  1  one-cycle write strobe
data_miso_rdy  in  1  one-cycle pulse, read transfer complete
data_miso  out  32  read data presented to SPI slave
ctrl_out  out  32  CTRL register contents
cmd_pulse  out  32  one-cycle pulses from CMD writes
status_in  in  32  live status, read-only
evt_in  in  EVT_W  event set pulses
wr_err  out  1  one-cycle pulse on write to unmapped or RO address

Behaviour:
- Register map (16-bit address, all 32-bit registers):
  - 0x0000 VERSION, RO.
  - 0x0001 SCRATCH, RW.
  - 0x0002 CTRL, RW.
  - 0x0003 CMD, write-1-pulse; reads 0.
  - 0x0004 STATUS, RO, returns status_in.
  - 0x0005 EVENT, sticky, clear-on-read; upper bits 0.
  - 0x0006 CNT, RO: [31:16] = accepted writes, [15:0] = completed reads. Each half is 16-bit and wraps.
  - 0x0007 IRQ_MASK, only when the optional feature is compiled in.
  - Any other address: reads return BAD_ADDR_VAL; writes are ignored.
- Reset values: data_miso=0, ctrl_out=0, cmd_pulse=0, wr_err=0, SCRATCH=0, EVENT=0, CNT=0, cur_addr=16'hFFFF.
- Read prefetch:
  - addr_rdy is delayed 1 cycle; in that cycle addr is captured into cur_addr and the snapshot is taken.
  - data_miso is registered from the map mux on the next cycle, i.e. valid 2 clk_100m cycles after addr_rdy.
  - Prefetch runs on every addr_rdy, because the bank has no read/write knowledge.
  - data_miso holds its value until the next prefetch.
- Timing requirement: SPI half-period ≥ 4 clk_100m cycles. System-level constraint: sclk ≤ 12.5 MHz.
- Write:
  - On data_mosi_rdy, decode cur_addr.
  - SCRATCH and CTRL load data_mosi.
  - CMD drives cmd_pulse=data_mosi for exactly 1 cycle, then returns to 0.
  - RO or unmapped address: no state change, wr_err pulses 1 cycle.
  - Valid write increments CNT[31:16].
- Read completion: on data_miso_rdy, CNT[15:0] increments.
- EVENT clear-on-read:
  - Only bits set in the snapshot taken at prefetch are cleared, and only when cur_addr==0x0005 at data_miso_rdy.
  - Events arriving after the snapshot survive.
  - evt_in set and clear on the same bit in the same cycle: set wins.
- data_mosi_rdy and data_miso_rdy together are not expected. If both occur, the write is processed and the read counter still increments.
- addr_rdy during a pending transfer: cur_addr is overwritten and any pending clear-on-read is discarded.
- rst_syn mid-transfer: everything returns to reset values next cycle, and no pulses are emitted.

Optional Feature:
Macro SPI_REGBANK_IRQ_EN.
- Defined:
  - Adds IRQ_MASK RW at 0x0007 (reset 0).
  - Adds output irq (1 bit) = registered OR of (EVENT & IRQ_MASK[EVT_W-1:0]), 1-cycle latency, reset 0.
- Not defined: no irq port; 0x0007 is unmapped.

Decomposition:
- Shared package/include alongside the existing 4MB parameters holds register address constants (ADDR_VERSION..ADDR_IRQ_MASK) and the default BAD_ADDR_VAL.
- One sub-module, spi_event_reg_4mb: EVT_W sticky bits, set vector, snapshot-on-capture, masked clear-on-commit, set-priority.

Test Plan:
- Reset then read 0x0000 → data_miso=32'h0001_0000 two cycles after addr_rdy; CNT read = 0x0000_0001 afterwards.
- Write 0x0001=0xA5A5_5A5A, read 0x0001 → 0xA5A5_5A5A; CNT[31:16]=1.
- Write 0x0003=0x0000_0005 → cmd_pulse=5 for exactly 1 clk, then 0.
- Pulse evt_in bit 3, read 0x0005 → bit 3 read as 1. Pulse bit 4 between prefetch and data_miso_rdy → second read returns 0x10 only.
- Write 0x0004 and 0x1234 → wr_err pulses twice, STATUS unaffected. Read 0x1234 → 0xDEAD_BEEF.
- Assert rst_syn between addr_rdy and data_mosi_rdy → no write occurs, all outputs return to reset values.
